regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the core's decode/issue stage, generalising the two-read/one-write register file to NREAD read ports and configurable width/depth. It adds a hardware clear sequencer that zeroes every entry after reset or on request, a `ready` status output, and a registered dropped-write flag. Write-to-read forwarding is selectable at compile time.

---
 rtl/regfile_mp.sv | 115 +++++++++++
 tb/tb_regfile_mp.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a hardware clear sweep after reset or on request.
// Optional same-cycle write-to-read forwarding is compiled in with REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  output logic                ready,
  output logic                wr_drop,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DW-1:0]       wdata,
  input  logic [NREAD-1:0]    re,
  input  logic [NREAD*AW-1:0] raddr,
  output logic [NREAD*DW-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ready_q;
  logic          wr_drop_q;
  logic          sweep_we;
  logic          zero_waddr;
  logic          wr_acc;
  logic          drop_d;
  logic [DW-1:0] regs_q [DEPTH];

  assign zero_waddr = (ZERO_REG != 0) && (waddr == '0);
  assign wr_acc     = ready_q && !clr && we && !zero_waddr;
  assign drop_d     = we && (!ready_q || clr);

  // Sweep sequencer: CLEAR walks every entry once, clr restarts it from entry 0.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sweep_we = 1'b0;
    case (state_q)
      S_CLEAR: begin
        sweep_we = 1'b1;
        if (clr) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
          if (ptr_q == PTR_LAST) begin
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_CLEAR;
      ptr_q     <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ready_q   <= (state_d == S_IDLE);
      wr_drop_q <= drop_d;
    end
  end

  // Storage has no reset; the sweep establishes its contents before ready rises.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      regs_q[ptr_q] <= '0;
    end else if (wr_acc) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign ready   = ready_q;
  assign wr_drop = wr_drop_q;

  for (genvar i = 0; i < int'(NREAD); i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          force_zero;

    assign ra         = raddr[i*AW +: AW];
    assign force_zero = !ready_q || !re[i] || ((ZERO_REG != 0) && (ra == '0));
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = wr_acc && (waddr == ra);
    assign rdata[i*DW +: DW] = force_zero ? '0 : (hit ? wdata : regs_q[ra]);
`else
    assign rdata[i*DW +: DW] = force_zero ? '0 : regs_q[ra];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (DW=32, AW=5, NREAD=2, ZERO_REG=1) against a behavioural model.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        ready;
  logic        wr_drop;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;

  int errors = 0;
  int checks = 0;

  regfile_mp #(.DW(32), .AW(5), .NREAD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready), .wr_drop(wr_drop),
    .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Model: cycles left until ready, contents, registered drop flag.
  int unsigned m_left;
  logic [31:0] m_mem [32];
  logic        m_drop;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_left = 32;
    m_drop = 1'b0;
    for (int a = 0; a < 32; a++) m_mem[a] = 32'h0;
  endtask

  function automatic bit m_accept();
    return we && (m_left == 0) && !clr && (waddr != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input int p);
    logic [4:0] a;
    a = raddr[p*5 +: 5];
    if (m_left != 0 || !re[p] || a == 5'd0) return 32'h0;
    if (BYP && m_accept() && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  task automatic model_edge();
    bit acc;
    acc    = m_accept();
    m_drop = we && (m_left != 0 || clr);
    if (acc) m_mem[waddr] = wdata;
    if (clr) begin
      m_left = 32;
      for (int a = 0; a < 32; a++) m_mem[a] = 32'h0;
    end else if (m_left > 0) begin
      m_left--;
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [1:0] r, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic c);
    we = w; waddr = wa; wdata = wd; re = r; raddr = {ra1, ra0}; clr = c;
  endtask

  task automatic idle_rand();
    drive(1'b0, 5'(($urandom)), 32'h0, 2'b11, 5'($urandom), 5'($urandom), 1'b0);
  endtask

  // Compare outputs with the model, then advance one clock; starts and ends at a negedge.
  task automatic cycle();
    #1;
    chk("ready", 64'(ready), 64'(m_left == 0));
    chk("wr_drop", 64'(wr_drop), 64'(m_drop));
    chk("rdata0", 64'(rdata[31:0]), 64'(m_read(0)));
    chk("rdata1", 64'(rdata[63:32]), 64'(m_read(1)));
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  task automatic count_low(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      idle_rand();
      #1;
      if (ready) done = 1'b1;
      else begin
        n++;
        cycle();
      end
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        edrop;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int n;
    tbl[0] = '{1'b1, 5'd7, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 5'd0, 32'h1, 2'b11, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0};
    tbl[3] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0};
    tbl[4] = '{1'b1, 5'd3, 32'hA5A5A5A5, 2'b11, 5'd7, 5'd3, 32'hDEADBEEF,
               (BYP ? 32'hA5A5A5A5 : 32'h0), 1'b0};
    tbl[5] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    tbl[6] = '{1'b0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd7, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[7] = '{1'b0, 5'd0, 32'h0, 2'b10, 5'd3, 5'd0, 32'h0, 32'h0, 1'b0};

    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0);
    model_reset();
    @(negedge clk);
    cycle(); cycle(); cycle();
    rst = 1'b1;

    // Reset release: 32 low cycles, then every entry reads zero.
    count_low(n);
    chk("reset_sweep_len", 64'(n), 64'd32);
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'h0, 2'b01, 5'(a), 5'd0, 1'b0);
      #1;
      chk("post_reset_zero", 64'(rdata[31:0]), 64'h0);
      cycle();
    end

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra0, tbl[i].ra1, 1'b0);
      #1;
      chk($sformatf("vec%0d_r0", i), 64'(rdata[31:0]), 64'(tbl[i].e0));
      chk($sformatf("vec%0d_r1", i), 64'(rdata[63:32]), 64'(tbl[i].e1));
      chk($sformatf("vec%0d_drop", i), 64'(wr_drop), 64'(tbl[i].edrop));
      cycle();
    end

    // Clear with a colliding write: drop pulse, 32 low cycles, entry cleared.
    drive(1'b1, 5'd9, 32'h12345678, 2'b00, 5'd0, 5'd0, 1'b0);
    cycle();
    drive(1'b1, 5'd9, 32'h55555555, 2'b00, 5'd0, 5'd0, 1'b1);
    cycle();
    idle_rand(); #1;
    chk("clr_drop_hi", 64'(wr_drop), 64'd1);
    cycle();
    idle_rand(); #1;
    chk("clr_drop_lo", 64'(wr_drop), 64'd0);
    cycle();
    count_low(n);
    chk("clr_sweep_len", 64'(n + 2), 64'd32);
    drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd7, 1'b0);
    #1;
    chk("clr_addr9_zero", 64'(rdata[31:0]), 64'h0);
    chk("clr_addr7_zero", 64'(rdata[63:32]), 64'h0);
    cycle();

    // Second clr at sweep cycle 10, with a write attempted mid-sweep.
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1);
    cycle();
    for (int j = 1; j <= 10; j++) begin
      idle_rand();
      if (j == 5) begin we = 1'b1; waddr = 5'd5; wdata = 32'hFFFF0000; end
      if (j == 10) clr = 1'b1;
      #1;
      if (j == 6) chk("sweep_drop_hi", 64'(wr_drop), 64'd1);
      if (j == 7) chk("sweep_drop_lo", 64'(wr_drop), 64'd0);
      cycle();
    end
    count_low(n);
    chk("reclr_sweep_len", 64'(n + 10), 64'd42);
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 1'b0);
    #1;
    chk("sweep_write_ignored", 64'(rdata[31:0]), 64'h0);
    cycle();

    // Reset at sweep cycle 15, held 3 cycles, then a full sweep.
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1);
    cycle();
    for (int j = 1; j <= 14; j++) begin
      idle_rand();
      if (j == 14) begin we = 1'b1; waddr = 5'd6; wdata = 32'h1; end
      cycle();
    end
    idle_rand();
    #1;
    chk("pre_rst_drop", 64'(wr_drop), 64'd1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_drop", 64'(wr_drop), 64'd0);
    cycle(); cycle(); cycle();
    rst = 1'b1;
    count_low(n);
    chk("rst_sweep_len", 64'(n), 64'd32);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom), 5'($urandom), $urandom, 2'($urandom), 5'($urandom),
            5'($urandom), 1'($urandom_range(0, 59) == 0));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
